branch_commit_unit: RTL

//  Branch commit stage (EX/MEM boundary) feeding the gshare predictor's EXMEM_* update port.
//  - Registers resolved control-flow info from EX and detects mispredictions.
//  - Issues a one-cycle front-end flush/redirect.
//  - Produces exactly one predictor update per committed control instruction.
//  - Keeps saturating branch and mispredict counters for performance analysis.

---
 rtl/branch_commit_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/branch_commit_unit.sv
// Branch commit stage at the EX/MEM boundary. Registers resolved control-flow
// info, detects mispredictions, drives a one-cycle flush/redirect, emits one
// predictor update per committed control instruction and keeps saturating
// branch/mispredict counters.
module branch_commit_unit #(
  parameter int unsigned INDEX_WIDTH   = 6,
  parameter int unsigned HISTORY_WIDTH = 8,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      stall_i,
  input  logic                      EX_valid_i,
  input  logic [31:0]               EX_pc_i,
  input  logic                      EX_is_ctrl_i,
  input  logic                      EX_br_taken_i,
  input  logic [31:0]               EX_target_i,
  input  logic                      EX_prediction_i,
  input  logic [31:0]               EX_pred_target_i,
  input  logic                      EX_btb_hit_i,
  input  logic [HISTORY_WIDTH-1:0]  EX_ghr_data_i,
  output logic [INDEX_WIDTH-1:0]    EXMEM_btb_wr_index_o,
  output logic [29-INDEX_WIDTH:0]   EXMEM_btb_wr_tag_o,
  output logic [31:0]               EXMEM_btb_wr_target_o,
  output logic [HISTORY_WIDTH-1:0]  EXMEM_pht_wr_index_o,
  output logic [HISTORY_WIDTH-1:0]  EXMEM_ghr_data_o,
  output logic                      EXMEM_btb_hit_o,
  output logic                      EXMEM_prediction_o,
  output logic                      EXMEM_br_decision_o,
  output logic                      EXMEM_is_jmp_o,
  output logic                      flush_o,
  output logic                      redirect_valid_o,
  output logic [31:0]               redirect_pc_o,
  output logic [CNT_WIDTH-1:0]      br_cnt_o,
  output logic [CNT_WIDTH-1:0]      mispred_cnt_o
);

  logic                     valid_q, valid_d;
  logic [31:0]              pc_q, pc_d;
  logic                     is_ctrl_q, is_ctrl_d;
  logic                     taken_q, taken_d;
  logic [31:0]              target_q, target_d;
  logic                     pred_q, pred_d;
  logic [31:0]              pred_target_q, pred_target_d;
  logic                     btb_hit_q, btb_hit_d;
  logic [HISTORY_WIDTH-1:0] ghr_q, ghr_d;
  logic                     done_q, done_d;
  logic [CNT_WIDTH-1:0]     br_cnt_q, br_cnt_d;
  logic [CNT_WIDTH-1:0]     mispred_cnt_q, mispred_cnt_d;

  logic ctrl;
  logic mis;
  logic fire_flush;
  logic fire_update;

  // Commit decision from the registered entry; done suppresses repeats under stall.
  always_comb begin
    ctrl        = valid_q & is_ctrl_q;
    mis         = ctrl & ((taken_q != pred_q) |
                          (taken_q & pred_q & (pred_target_q != target_q)));
    fire_flush  = mis & ~done_q;
    fire_update = ctrl & ~done_q;
  end

  // Stage register next state: flush bubble, then stall hold, then capture.
  always_comb begin
    valid_d       = valid_q;
    pc_d          = pc_q;
    is_ctrl_d     = is_ctrl_q;
    taken_d       = taken_q;
    target_d      = target_q;
    pred_d        = pred_q;
    pred_target_d = pred_target_q;
    btb_hit_d     = btb_hit_q;
    ghr_d         = ghr_q;
    done_d        = done_q;
    if (fire_flush) begin
      valid_d = 1'b0;
      done_d  = 1'b0;
    end else if (stall_i) begin
      done_d  = 1'b1;
    end else begin
      valid_d       = EX_valid_i;
      pc_d          = EX_pc_i;
      is_ctrl_d     = EX_is_ctrl_i;
      taken_d       = EX_br_taken_i;
      target_d      = EX_target_i;
      pred_d        = EX_prediction_i;
      pred_target_d = EX_pred_target_i;
      btb_hit_d     = EX_btb_hit_i;
      ghr_d         = EX_ghr_data_i;
      done_d        = 1'b0;
    end
  end

  // Saturating performance counters.
  always_comb begin
    br_cnt_d      = br_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (fire_update && (br_cnt_q != '1))
      br_cnt_d = br_cnt_q + 1'b1;
    if (fire_flush && (mispred_cnt_q != '1))
      mispred_cnt_d = mispred_cnt_q + 1'b1;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q       <= 1'b0;
      pc_q          <= '0;
      is_ctrl_q     <= 1'b0;
      taken_q       <= 1'b0;
      target_q      <= '0;
      pred_q        <= 1'b0;
      pred_target_q <= '0;
      btb_hit_q     <= 1'b0;
      ghr_q         <= '0;
      done_q        <= 1'b0;
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      pc_q          <= pc_d;
      is_ctrl_q     <= is_ctrl_d;
      taken_q       <= taken_d;
      target_q      <= target_d;
      pred_q        <= pred_d;
      pred_target_q <= pred_target_d;
      btb_hit_q     <= btb_hit_d;
      ghr_q         <= ghr_d;
      done_q        <= done_d;
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Output mapping; redirect_pc is gated so an idle stage reads 0.
  always_comb begin
    EXMEM_btb_wr_index_o  = pc_q[INDEX_WIDTH+1:2];
    EXMEM_btb_wr_tag_o    = pc_q[31:INDEX_WIDTH+2];
    EXMEM_btb_wr_target_o = target_q;
    EXMEM_pht_wr_index_o  = pc_q[HISTORY_WIDTH+1:2];
    EXMEM_ghr_data_o      = ghr_q;
    EXMEM_btb_hit_o       = btb_hit_q;
    EXMEM_prediction_o    = pred_q;
    EXMEM_br_decision_o   = taken_q;
    EXMEM_is_jmp_o        = fire_update;
    flush_o               = fire_flush;
    redirect_valid_o      = fire_flush;
    redirect_pc_o         = ctrl ? (taken_q ? target_q : pc_q + 32'd4) : '0;
    br_cnt_o              = br_cnt_q;
    mispred_cnt_o         = mispred_cnt_q;
  end

endmodule
